// File: rtl/seq_timer_dev_if.sv
// Sequencer oreg slot into the timer and readback byte out to a sequencer ireg.
interface seq_timer_dev_if;
  logic [11:0] oreg;
  logic        oreg_wen;
  logic [7:0]  status;

  modport master (output oreg, output oreg_wen, input status);
  modport slave  (input oreg, input oreg_wen, output status);
endinterface

// File: rtl/seq_timer_dev.sv
// Programmable prescaled down-counting timer on a sequencer oreg slot.
// Any command edge pre-empts the prescaler, so the tick is skipped for that edge.
module seq_timer_dev #(
  parameter logic [7:0] DEV_ID = 8'hA1
) (
  input  logic           clock,
  input  logic           reset,
  seq_timer_dev_if.slave bus
);

  localparam logic [3:0] C_NOP    = 4'h0;
  localparam logic [3:0] C_SETPRE = 4'h1;
  localparam logic [3:0] C_SETCNT = 4'h2;
  localparam logic [3:0] C_START  = 4'h3;
  localparam logic [3:0] C_STOP   = 4'h4;
  localparam logic [3:0] C_ACK    = 4'h5;
  localparam logic [3:0] C_SEL    = 4'h6;

  logic       r_run;
  logic       r_auto;
  logic [7:0] r_pre_rld;
  logic [7:0] r_pre_cnt;
  logic [7:0] r_cnt_rld;
  logic [7:0] r_cnt;
  logic       r_done;
  logic       r_ovr;
  logic       r_err;
  logic [1:0] r_sel;

  logic [3:0] w_cmd;
  logic [7:0] w_data;

  assign w_cmd  = bus.oreg[11:8];
  assign w_data = bus.oreg[7:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_run     <= 1'b0;
      r_auto    <= 1'b0;
      r_pre_rld <= 8'd0;
      r_pre_cnt <= 8'd0;
      r_cnt_rld <= 8'd0;
      r_cnt     <= 8'd0;
      r_done    <= 1'b0;
      r_ovr     <= 1'b0;
      r_err     <= 1'b0;
      r_sel     <= 2'd0;
    end else if (bus.oreg_wen) begin
      case (w_cmd)
        C_NOP: ;
        C_SETPRE: r_pre_rld <= w_data;
        C_SETCNT: begin
          r_cnt_rld <= w_data;
          if (!r_run) r_cnt <= w_data;
        end
        C_START: begin
          r_run     <= 1'b1;
          r_auto    <= w_data[0];
          r_pre_cnt <= r_pre_rld;
        end
        C_STOP: r_run <= 1'b0;
        C_ACK: begin
          if (w_data[0]) r_done <= 1'b0;
          if (w_data[1]) r_ovr  <= 1'b0;
          if (w_data[2]) r_err  <= 1'b0;
        end
        C_SEL: r_sel <= w_data[1:0];
        default: r_err <= 1'b1;
      endcase
    end else if (r_run) begin
      if (r_pre_cnt == 8'd0) begin
        r_pre_cnt <= r_pre_rld;
        // A count of 0 or 1 expires on the first tick
        if (r_cnt > 8'd1) begin
          r_cnt <= r_cnt - 8'd1;
        end else begin
          r_done <= 1'b1;
          if (r_done) r_ovr <= 1'b1;
          if (r_auto) begin
            r_cnt <= r_cnt_rld;
          end else begin
            r_cnt <= 8'd0;
            r_run <= 1'b0;
          end
        end
      end else begin
        r_pre_cnt <= r_pre_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    bus.status = 8'h00;
    case (r_sel)
      2'd0: bus.status = {7'b0, r_done};
      2'd1: bus.status = r_cnt;
      2'd2: bus.status = {r_run, r_auto, 3'b0, r_err, r_ovr, r_done};
      default: bus.status = DEV_ID;
    endcase
  end

endmodule

// File: doc/seq_timer_dev.md
Name: seq_timer_dev

Overview:
- Programmable timer peripheral that sits on the responder end of the sequencer's output-register bus.
- It decodes one 12-bit oreg slot, {cmd[11:8], data[7:0]}, qualified by a single write-enable bit.
- It returns an 8-bit readback byte that is wired to one sequencer ireg input, so sequencer programs can load, start, stop and acknowledge the timer.
- Sequencer programs can block on expiry with a wait-nonzero instruction against this byte.

Parameters:
- DEV_ID, 8'hA1, constant returned when readback select = 3.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- oreg  in  12  command word: [11:8] cmd, [7:0] data. Sampled only when oreg_wen=1.
- oreg_wen  in  1  write strobe for this device's slot (one bit of the sequencer's one-hot oreg_wen).
- status  out  8  readback byte to the sequencer ireg. Combinational mux of registered state only; no path from oreg.

Behaviour:
- State:
  - run (1)
  - auto (1)
  - pre_rld, pre_cnt, cnt_rld, cnt (8 each)
  - done, ovr, err (sticky, 1 each)
  - sel (2)
- Reset:
  - All state is cleared to 0; status = 8'h00.
  - Reset mid-count aborts immediately; reset has priority over commands and ticks.
- Commands act at the clock edge where oreg_wen=1. oreg is ignored when oreg_wen=0.
  - 0x0 NOP: no effect.
  - 0x1 SETPRE: pre_rld = data.
  - 0x2 SETCNT: cnt_rld = data. If run=0, cnt = data as well. If run=1, the current count is untouched.
  - 0x3 START: run = 1; auto = data[0]; pre_cnt = pre_rld; cnt unchanged. START while already running restarts the prescaler only.
  - 0x4 STOP: run = 0; cnt and pre_cnt hold.
  - 0x5 ACK: data[0] clears done, data[1] clears ovr, data[2] clears err.
  - 0x6 SEL: sel = data[1:0].
  - 0x7..0xF: no effect except err = 1.
- Prescaler (evaluated each cycle while run=1 and no command that edge):
  - If pre_cnt == 0: assert tick; pre_cnt = pre_rld.
  - Otherwise: pre_cnt = pre_cnt - 1.
  - This gives tick period = pre_rld + 1 cycles.
- On tick:
  - If cnt > 1: cnt = cnt - 1.
  - Otherwise (cnt is 0 or 1), expire:
    - done = 1; ovr = 1 if done was already 1.
    - If auto = 1: cnt = cnt_rld and run stays 1.
    - If auto = 0: cnt = 0 and run = 0.
- Latency:
  - done rises max(cnt,1) × (pre_rld + 1) edges after the START edge.
  - status reflects the new value in the cycle after that edge.
- Priority:
  - Any command accepted on an edge suppresses the prescaler/tick for that edge; pre_cnt holds unless the command sets it.
  - Consequently, STOP coinciding with a would-be expiry wins (done not set), and ACK on an expiry edge defers the expiry one cycle, so done ends up set.
- Arithmetic: all counters are 8-bit unsigned with no wrap. cnt never decrements below 0.
- status mux:
  - sel=0: {7'b0, done}. Intended target for the sequencer wait-nonzero instruction.
  - sel=1: cnt.
  - sel=2: {run, auto, 3'b0, err, ovr, done}.
  - sel=3: DEV_ID.

Test Plan:
- Reset, then read all four sel values -> status = 00, 00, 00, A1 respectively; no state changes while oreg_wen=0 with random oreg.
- SETPRE 0x00, SETCNT 0x03, START data=0 -> cnt reads 2, 1, then done; done=1 and run=0 on the 3rd edge after the START edge; sel=2 reads 0x01.
- SETPRE 0x02, SETCNT 0x02, START data=1 -> done at edge 6 and cnt reloads to 2; ovr=1 at edge 12 without ACK; status(sel=2) = 0xC3; ACK 0x03 -> 0xC0.
- Running with pre_rld=0, cnt=1: issue STOP on the edge the tick would expire -> done stays 0, run=0, cnt=1; START again -> done one edge later.
- cmd 0x9 with oreg_wen=1 -> err=1 and sel=2 reads 0x04; the same cmd with oreg_wen=0 -> no change; ACK 0x04 clears it.
- Assert reset for one cycle mid-count (cnt=0x40, run=1) -> next cycle all fields zero and status = 0x00 under sel=0.
